masked_nibble_sequencer: RTL
============================

# masked_nibble_sequencer

Serialising driver and write-back stage for the 3-share (second-order) masked 4-bit G S-box stage of the LED round datapath. It loads a 64-bit state held as three Boolean shares and issues one nibble triple per cycle, with 18 bits of fresh randomness, to the G stage. It captures the G outputs after the stage's fixed latency and writes them back in place, so after 16 nibbles the register holds the shared S-box-layer result. Shares are never combined inside this block.

## Interface
- NIBBLES, 16: nibbles per state; state width is 4*NIBBLES.
- G_LAT, 1: G-stage latency in cycles, from inputs presented to outputs valid.
- RAND_W, 18: fresh-randomness width per G invocation.
- clk  input  1  clock, all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load state_in* and begin; sampled only in IDLE.
- state_in1/2/3  input  64  state shares 0/1/2.
- rnd_in  input  RAND_W  fresh randomness.
- rnd_valid  input  1  rnd_in valid this cycle.
- rnd_ready  output  1  combinational; high in ISSUE; randomness consumed when rnd_valid && rnd_ready.
- g_in1/2/3  output  4  registered nibble shares to the G stage.
- g_r  output  RAND_W  registered randomness to the G stage.
- g_out1/2/3  input  4  G-stage result shares.
- busy  output  1  high in ISSUE or DRAIN.
- done  output  1  one-cycle pulse when the result is complete.
- state_out1/2/3  output  64  state share registers, meaningful when busy is low.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE on start: loads state regs from state_in*, clears idx and the tag pipe.
  - ISSUE: on each edge where rnd_valid=1, issue nibble idx (bits [4*idx+3:4*idx] of each share) and increment idx.
  - ISSUE→DRAIN on the edge that issues idx=NIBBLES-1.
  - DRAIN→DONE on the edge performing the final write-back.
  - DONE→IDLE unconditionally.
- Issue edge: g_in1/2/3 take the nibble from share regs 1/2/3; g_r takes rnd_in. On every non-issue edge g_in* and g_r are loaded with 0, so no stale share is presented to the G stage.
- Tag pipe: a shift register of depth G_LAT+1 carrying {valid, idx}; it advances every cycle, in every state.
- When a valid tag exits the pipe, the state nibble at tag.idx in share k is replaced by g_outk. No other nibble changes.
- rnd_valid=0 in ISSUE is a stall: nothing is issued, idx holds, and in-flight tags still drain and write back.
- start is ignored outside IDLE. start is also ignored in the DONE cycle; it is honoured in the following IDLE cycle.
- Reset, asynchronous, in any state:
  - FSM goes to IDLE; idx, tags, state regs, g_in*, g_r, busy and done all go to 0.
  - In-flight G results are discarded.
- Outputs after reset: every output is 0. rnd_ready is 0.

## Timing
- Cycle k is the period after rising edge Ek; start is sampled at E0.
- Without stalls:
  - Nibble i is issued at E(i+1) and is on g_in* during cycle i+1.
  - g_out* for nibble i are valid in cycle i+1+G_LAT and are written back at E(i+2+G_LAT).
  - busy is high in cycles 1..NIBBLES+G_LAT.
  - done is high in cycle NIBBLES+G_LAT+1 (cycle 18 at defaults).
  - Back in IDLE at cycle NIBBLES+G_LAT+2.
- Each stalled ISSUE cycle delays done by exactly one cycle.
- A write-back may coincide with an issue edge. They touch different nibbles and both take effect.
- rnd_ready has no combinational path from rnd_valid.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-clock, then release -> every output 0, busy=0, rnd_ready=0; start=0 for 5 cycles -> outputs stay 0.
- Full run with stub G (G_LAT=1, returns g_in1^4'hF, g_in2, g_in3 one cycle later): state_in1=64'h0123456789ABCDEF, state_in2=state_in3=0, rnd_valid=1 -> done exactly in cycle 18, state_out1=64'hFEDCBA9876543210, state_out2=state_out3=0.
- Stalls: same stimulus, rnd_valid low on alternate ISSUE cycles starting from cycle 1 -> 16 stall cycles, done in cycle 34, identical result; g_r equals rnd_in sampled at each issue edge; g_in*/g_r are 0 in every cycle following a stall.
- Shares: random state_in shares and rnd_in with a golden 2nd-order G model -> XOR of state_out shares equals the unmasked LED S-box layer of the XOR of state_in shares; no cycle presents two shares of the same nibble on one port.
- start while busy: pulse start in cycle 5 with different state_in -> ignored, original result produced; start pulsed in the DONE cycle -> ignored; start in the next cycle -> new run begins.
- Reset mid-operation: drop rst_n in cycle 8 -> all outputs 0 asynchronously, no late write-back after release; subsequent start completes normally with done in cycle 18 relative to the new start.

Source files
------------

// File: rtl/masked_nibble_sequencer.sv
// Serialising driver / write-back stage for a 3-share masked 4-bit G S-box stage.
// Issues one nibble triple per randomness beat and writes G results back in place.
module masked_nibble_sequencer #(
    parameter int NIBBLES = 16,
    parameter int G_LAT   = 1,
    parameter int RAND_W  = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in1,
    input  logic [4*NIBBLES-1:0] state_in2,
    input  logic [4*NIBBLES-1:0] state_in3,
    input  logic [RAND_W-1:0]    rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [3:0]           g_in1,
    output logic [3:0]           g_in2,
    output logic [3:0]           g_in3,
    output logic [RAND_W-1:0]    g_r,
    input  logic [3:0]           g_out1,
    input  logic [3:0]           g_out2,
    input  logic [3:0]           g_out3,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out1,
    output logic [4*NIBBLES-1:0] state_out2,
    output logic [4*NIBBLES-1:0] state_out3
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] get_nibble(input logic [W-1:0] s, input logic [IDX_W-1:0] i);
        return s[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [W-1:0] put_nibble(input logic [W-1:0] s, input logic [IDX_W-1:0] i,
                                                 input logic [3:0] n);
        logic [W-1:0] r;
        r = s;
        r[{i, 2'b00} +: 4] = n;
        return r;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [IDX_W-1:0]    idx_r;
    logic                tag_valid_r [0:G_LAT];
    logic [IDX_W-1:0]    tag_idx_r   [0:G_LAT];
    logic [W-1:0]        share1_r;
    logic [W-1:0]        share2_r;
    logic [W-1:0]        share3_r;
    logic [3:0]          g_in1_r;
    logic [3:0]          g_in2_r;
    logic [3:0]          g_in3_r;
    logic [RAND_W-1:0]   g_r_r;
    logic                busy_r;
    logic                done_r;

    logic                load_s;
    logic                issue_s;
    logic                wb_s;
    logic [IDX_W-1:0]    wb_idx_s;

    assign load_s   = (state_r == ST_IDLE) && start;
    assign issue_s  = (state_r == ST_ISSUE) && rnd_valid;
    assign wb_s     = tag_valid_r[G_LAT];
    assign wb_idx_s = tag_idx_r[G_LAT];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (idx_r == LAST_IDX)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (wb_s && (wb_idx_s == LAST_IDX)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Issue index: cleared on load, advanced once per consumed randomness beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (load_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (issue_s) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Tag pipe tracks which nibble each G result belongs to; it shifts every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= G_LAT; j++) begin
                tag_valid_r[j] <= 1'b0;
                tag_idx_r[j]   <= {IDX_W{1'b0}};
            end
        end else if (load_s) begin
            for (int j = 0; j <= G_LAT; j++) begin
                tag_valid_r[j] <= 1'b0;
                tag_idx_r[j]   <= {IDX_W{1'b0}};
            end
        end else begin
            tag_valid_r[0] <= issue_s;
            tag_idx_r[0]   <= idx_r;
            for (int j = 1; j <= G_LAT; j++) begin
                tag_valid_r[j] <= tag_valid_r[j-1];
                tag_idx_r[j]   <= tag_idx_r[j-1];
            end
        end
    end

    // Share registers: load whole state, or replace one nibble per share on write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share1_r <= {W{1'b0}};
            share2_r <= {W{1'b0}};
            share3_r <= {W{1'b0}};
        end else if (load_s) begin
            share1_r <= state_in1;
            share2_r <= state_in2;
            share3_r <= state_in3;
        end else if (wb_s) begin
            share1_r <= put_nibble(share1_r, wb_idx_s, g_out1);
            share2_r <= put_nibble(share2_r, wb_idx_s, g_out2);
            share3_r <= put_nibble(share3_r, wb_idx_s, g_out3);
        end else begin
            share1_r <= share1_r;
            share2_r <= share2_r;
            share3_r <= share3_r;
        end
    end

    // G-stage operands: zeroed on every non-issue edge so no stale share lingers on a port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_in1_r <= 4'h0;
            g_in2_r <= 4'h0;
            g_in3_r <= 4'h0;
            g_r_r   <= {RAND_W{1'b0}};
        end else if (issue_s) begin
            g_in1_r <= get_nibble(share1_r, idx_r);
            g_in2_r <= get_nibble(share2_r, idx_r);
            g_in3_r <= get_nibble(share3_r, idx_r);
            g_r_r   <= rnd_in;
        end else begin
            g_in1_r <= 4'h0;
            g_in2_r <= 4'h0;
            g_in3_r <= 4'h0;
            g_r_r   <= {RAND_W{1'b0}};
        end
    end

    // Status flags registered alongside the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_ISSUE) || (next_state_s == ST_DRAIN);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign rnd_ready  = (state_r == ST_ISSUE);
    assign g_in1      = g_in1_r;
    assign g_in2      = g_in2_r;
    assign g_in3      = g_in3_r;
    assign g_r        = g_r_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign state_out1 = share1_r;
    assign state_out2 = share2_r;
    assign state_out3 = share3_r;

endmodule
